sram_arbiter: RTL and testbench

- Shares the single-port 128-bit test SRAM (read/write strobes, 16-bit addr, write_data/read_data) between two requesters.
- Requester BUS is the AHB-side slave interface (key/data writes, data reads); requester CORE is the AES core (key/data reads, result writes).
- Serialises accesses into a fixed setup/strobe/complete sequence and arbitrates round-robin on ties.
- Range-checks addresses and reports errors to the issuing requester without touching the SRAM.

---
 rtl/sram_arbiter_if.sv | 53 +++++
 rtl/sram_arbiter.sv | 114 +++++++++++
 tb/tb_sram_arbiter.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// Request/response signals between the two requesters, the arbiter and the test SRAM.
interface sram_arbiter_if #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 16
);
   logic              bus_req;
   logic              bus_wr;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_gnt;
   logic              bus_done;
   logic              bus_err;
   logic [DATA_W-1:0] bus_rdata;

   logic              core_req;
   logic              core_wr;
   logic [ADDR_W-1:0] core_addr;
   logic [DATA_W-1:0] core_wdata;
   logic              core_gnt;
   logic              core_done;
   logic              core_err;
   logic [DATA_W-1:0] core_rdata;

   logic              sram_read;
   logic              sram_write;
   logic [ADDR_W-1:0] sram_addr;
   logic [DATA_W-1:0] sram_wdata;
   logic [DATA_W-1:0] sram_rdata;

   logic              busy;

   // Arbiter side
   modport slave (
      input  bus_req, bus_wr, bus_addr, bus_wdata,
      output bus_gnt, bus_done, bus_err, bus_rdata,
      input  core_req, core_wr, core_addr, core_wdata,
      output core_gnt, core_done, core_err, core_rdata,
      output sram_read, sram_write, sram_addr, sram_wdata,
      input  sram_rdata,
      output busy
   );

   // Requester / SRAM side
   modport master (
      output bus_req, bus_wr, bus_addr, bus_wdata,
      input  bus_gnt, bus_done, bus_err, bus_rdata,
      output core_req, core_wr, core_addr, core_wdata,
      input  core_gnt, core_done, core_err, core_rdata,
      input  sram_read, sram_write, sram_addr, sram_wdata,
      output sram_rdata,
      input  busy
   );
endinterface

// File: rtl/sram_arbiter.sv
// Two-requester arbiter for the single-port test SRAM. Each access runs
// IDLE -> SETUP -> ACCESS -> DONE; out-of-range addresses short-cut through
// ERRDONE without strobing the SRAM. Ties go to the requester not served last.
module sram_arbiter #(
   parameter int DATA_W = 128,
   parameter int ADDR_W = 16,
   parameter int DEPTH  = 64
) (
   input  logic           clk,
   input  logic           rst,
   sram_arbiter_if.slave  io
);

   typedef enum logic [2:0] {IDLE, SETUP, ACCESS, DONE, ERRDONE} state_t;
   typedef enum logic {OWN_BUS, OWN_CORE} owner_t;

   state_t            state;
   owner_t            last_owner;
   owner_t            owner_q;
   logic              wr_q;

   logic              bus_wins;
   logic              sel_wr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              addr_ok;

   // Pick the winning requester and its command for capture in IDLE
   always_comb begin
      bus_wins  = io.bus_req && (!io.core_req || last_owner == OWN_CORE);
      sel_wr    = bus_wins ? io.bus_wr    : io.core_wr;
      sel_addr  = bus_wins ? io.bus_addr  : io.core_addr;
      sel_wdata = bus_wins ? io.bus_wdata : io.core_wdata;
      addr_ok   = sel_addr < ADDR_W'(DEPTH);
   end

   // Access sequencer; all outputs registered alongside the state.
   // sram_addr/sram_wdata double as the captured command registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         last_owner    <= OWN_CORE;
         owner_q       <= OWN_BUS;
         wr_q          <= 1'b0;
         io.bus_gnt    <= 1'b0;
         io.bus_done   <= 1'b0;
         io.bus_err    <= 1'b0;
         io.bus_rdata  <= '0;
         io.core_gnt   <= 1'b0;
         io.core_done  <= 1'b0;
         io.core_err   <= 1'b0;
         io.core_rdata <= '0;
         io.sram_read  <= 1'b0;
         io.sram_write <= 1'b0;
         io.sram_addr  <= '0;
         io.sram_wdata <= '0;
         io.busy       <= 1'b0;
      end else begin
         io.bus_gnt   <= 1'b0;
         io.bus_done  <= 1'b0;
         io.bus_err   <= 1'b0;
         io.core_gnt  <= 1'b0;
         io.core_done <= 1'b0;
         io.core_err  <= 1'b0;
         case (state)
            IDLE: begin
               if (io.bus_req || io.core_req) begin
                  owner_q     <= bus_wins ? OWN_BUS : OWN_CORE;
                  last_owner  <= bus_wins ? OWN_BUS : OWN_CORE;
                  wr_q        <= sel_wr;
                  io.busy     <= 1'b1;
                  io.bus_gnt  <= bus_wins;
                  io.core_gnt <= !bus_wins;
                  if (addr_ok) begin
                     state         <= SETUP;
                     io.sram_addr  <= sel_addr;
                     io.sram_wdata <= sel_wr ? sel_wdata : '0;
                  end else begin
                     state        <= ERRDONE;
                     io.bus_done  <= bus_wins;
                     io.bus_err   <= bus_wins;
                     io.core_done <= !bus_wins;
                     io.core_err  <= !bus_wins;
                  end
               end
            end
            SETUP: begin
               io.sram_read  <= !wr_q;
               io.sram_write <= wr_q;
               state         <= ACCESS;
            end
            ACCESS: begin
               io.sram_read  <= 1'b0;
               io.sram_write <= 1'b0;
               io.sram_addr  <= '0;
               io.sram_wdata <= '0;
               state         <= DONE;
               if (owner_q == OWN_BUS) begin
                  io.bus_done <= 1'b1;
                  if (!wr_q) io.bus_rdata <= io.sram_rdata;
               end else begin
                  io.core_done <= 1'b1;
                  if (!wr_q) io.core_rdata <= io.sram_rdata;
               end
            end
            default: begin
               state   <= IDLE;
               io.busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (reference memory, per-requester rdata,
// last-served owner).
module tb_sram_arbiter;

   localparam int DW    = 128;
   localparam int AW    = 16;
   localparam int DEPTH = 64;
   localparam int AIW   = $clog2(DEPTH);

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sram_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) io ();

   sram_arbiter #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .io  (io)
   );

   // SRAM model
   logic [DW-1:0]  mem [DEPTH];
   logic           fill;
   logic [AIW-1:0] fill_idx;
   logic [DW-1:0]  fill_data;
   assign io.sram_rdata = io.sram_read ? mem[io.sram_addr[AIW-1:0]] : '0;
   always @(posedge clk) begin
      if (fill) mem[fill_idx] <= fill_data;
      else if (io.sram_write) mem[io.sram_addr[AIW-1:0]] <= io.sram_wdata;
   end

   // Reference model state
   logic [DW-1:0] ref_mem [DEPTH];
   logic [DW-1:0] ref_rd  [2];   // 0 = BUS, 1 = CORE
   int            ref_last;      // owner served last
   int            total = 0;
   int            bad   = 0;

   function automatic logic [DW-1:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic clear_inputs();
      io.bus_req = 0; io.bus_wr = 0; io.bus_addr = '0; io.bus_wdata = '0;
      io.core_req = 0; io.core_wr = 0; io.core_addr = '0; io.core_wdata = '0;
   endtask

   task automatic drive(input int who, input logic req, input logic wr,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
      if (who == 0) begin
         io.bus_req = req; io.bus_wr = wr; io.bus_addr = addr; io.bus_wdata = data;
      end else begin
         io.core_req = req; io.core_wr = wr; io.core_addr = addr; io.core_wdata = data;
      end
   endtask

   task automatic do_reset();
      rst = 1;
      @(negedge clk);
      @(negedge clk);
      rst = 0;
      ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1;
   endtask

   task automatic test_reset();
      rst = 1;
      drive(0, 1, 1, 16'd3, rnd128());
      drive(1, 1, 0, 16'd4, rnd128());
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({io.bus_gnt, io.bus_done, io.bus_err, io.core_gnt, io.core_done, io.core_err,
           io.sram_read, io.sram_write, io.busy} !== 9'b0) begin
         bad++; $display("FAIL rst_flags: got %b want 0", {io.bus_gnt, io.bus_done, io.bus_err,
            io.core_gnt, io.core_done, io.core_err, io.sram_read, io.sram_write, io.busy});
      end
      total++;
      if (io.sram_addr !== '0) begin bad++; $display("FAIL rst_addr: got %h want 0", io.sram_addr); end
      total++;
      if (io.sram_wdata !== '0) begin bad++; $display("FAIL rst_wdata: got %h want 0", io.sram_wdata); end
      total++;
      if (io.bus_rdata !== '0 || io.core_rdata !== '0) begin
         bad++; $display("FAIL rst_rdata: got %h/%h want 0", io.bus_rdata, io.core_rdata);
      end
      clear_inputs();
      rst = 0;
      ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1;
   endtask

   task automatic test_bus_write();
      logic [DW-1:0] wd;
      wd = 128'h00112233_44556677_8899AABB_CCDDEEFF;
      drive(0, 1, 1, 16'd0, wd);
      @(negedge clk);  // SETUP
      total++;
      if ({io.bus_gnt, io.core_gnt, io.sram_read, io.sram_write} !== 4'b1000) begin
         bad++; $display("FAIL bw_gnt: got %b want 1000", {io.bus_gnt, io.core_gnt, io.sram_read, io.sram_write});
      end
      drive(0, 0, 0, 16'd9, '0);
      @(negedge clk);  // ACCESS
      total++;
      if ({io.sram_read, io.sram_write} !== 2'b01 || io.sram_addr !== 16'd0 || io.sram_wdata !== wd) begin
         bad++; $display("FAIL bw_strobe: got r%b w%b a%h d%h want w1 a0 d%h",
            io.sram_read, io.sram_write, io.sram_addr, io.sram_wdata, wd);
      end
      @(negedge clk);  // DONE
      total++;
      if ({io.bus_done, io.bus_err, io.core_done} !== 3'b100) begin
         bad++; $display("FAIL bw_done: got %b want 100", {io.bus_done, io.bus_err, io.core_done});
      end
      ref_mem[0] = wd; ref_last = 0;
      @(negedge clk);  // IDLE
      total++;
      if (io.busy !== 1'b0) begin bad++; $display("FAIL bw_idle: busy got %b want 0", io.busy); end
      drive(0, 1, 0, 16'd0, '0);
      @(negedge clk);
      drive(0, 0, 0, 16'd0, '0);
      @(negedge clk);
      total++;
      if (io.sram_read !== 1'b1) begin bad++; $display("FAIL br_strobe: got %b want 1", io.sram_read); end
      @(negedge clk);
      ref_rd[0] = ref_mem[0];
      total++;
      if (io.bus_done !== 1'b1 || io.bus_rdata !== ref_rd[0]) begin
         bad++; $display("FAIL br_rdata: done %b got %h want %h", io.bus_done, io.bus_rdata, ref_rd[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_tie();
      logic [DW-1:0] wd;
      do_reset();
      wd = rnd128();
      drive(0, 1, 1, 16'd32, wd);
      drive(1, 1, 0, 16'd0, '0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1) begin
            total++;
            if ({io.bus_gnt, io.core_gnt} !== 2'b10) begin
               bad++; $display("FAIL tie_first: got %b want 10", {io.bus_gnt, io.core_gnt});
            end
            drive(0, 0, 0, '0, '0);
         end
         if (c == 3) begin
            total++;
            if ({io.bus_done, io.core_done} !== 2'b10) begin
               bad++; $display("FAIL tie_bdone: got %b want 10", {io.bus_done, io.core_done});
            end
            ref_mem[32] = wd;
         end
         if (c == 5) begin
            total++;
            if ({io.bus_gnt, io.core_gnt} !== 2'b01) begin
               bad++; $display("FAIL tie_cgnt: got %b want 01", {io.bus_gnt, io.core_gnt});
            end
            drive(1, 0, 0, '0, '0);
         end
         if (c == 7) begin
            ref_rd[1] = ref_mem[0];
            total++;
            if (io.core_done !== 1'b1 || io.core_rdata !== ref_rd[1]) begin
               bad++; $display("FAIL tie_cdone: done %b got %h want %h", io.core_done, io.core_rdata, ref_rd[1]);
            end
         end
      end
      ref_last = 1;
      drive(0, 1, 0, 16'd32, '0);
      drive(1, 1, 0, 16'd32, '0);
      @(negedge clk);
      total++;
      if ({io.bus_gnt, io.core_gnt} !== 2'b10) begin
         bad++; $display("FAIL tie_second: got %b want 10", {io.bus_gnt, io.core_gnt});
      end
      clear_inputs();
      @(negedge clk);
      @(negedge clk);
      ref_rd[0] = ref_mem[32]; ref_last = 0;
      total++;
      if (io.bus_rdata !== ref_rd[0]) begin
         bad++; $display("FAIL tie_rd32: got %h want %h", io.bus_rdata, ref_rd[0]);
      end
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 0, 16'd0, '0);
      for (int c = 1; c <= 8; c++) begin
         @(negedge clk);
         if (c == 1 || c == 4 || c == 5) begin
            total++;
            if (io.core_gnt !== (c != 4)) begin
               bad++; $display("FAIL b2b_gnt%0d: got %b want %b", c, io.core_gnt, c != 4);
            end
         end
         if (c == 1) drive(1, 1, 0, 16'd32, '0);
         if (c == 5) drive(1, 0, 0, '0, '0);
         if (c == 3 || c == 7) begin
            ref_rd[1] = ref_mem[(c == 3) ? 0 : 32];
            total++;
            if (io.core_done !== 1'b1 || io.core_rdata !== ref_rd[1]) begin
               bad++; $display("FAIL b2b_rd%0d: done %b got %h want %h", c, io.core_done, io.core_rdata, ref_rd[1]);
            end
         end
      end
      ref_last = 1;
   endtask

   task automatic test_out_of_range();
      drive(0, 1, 0, 16'd64, '0);
      @(negedge clk);
      total++;
      if ({io.bus_gnt, io.bus_done, io.bus_err, io.sram_read, io.core_gnt} !== 5'b11100) begin
         bad++; $display("FAIL oor_pulse: got %b want 11100",
            {io.bus_gnt, io.bus_done, io.bus_err, io.sram_read, io.core_gnt});
      end
      drive(0, 0, 0, '0, '0);
      @(negedge clk);
      total++;
      if (io.sram_read !== 1'b0 || io.busy !== 1'b0 || io.bus_rdata !== ref_rd[0]) begin
         bad++; $display("FAIL oor_after: r%b busy%b got %h want %h", io.sram_read, io.busy, io.bus_rdata, ref_rd[0]);
      end
      ref_last = 0;
   endtask

   task automatic test_reset_in_access();
      logic [DW-1:0] wd;
      wd = rnd128();
      drive(0, 1, 1, 16'd7, wd);
      @(negedge clk);
      drive(0, 0, 0, '0, '0);
      @(negedge clk);
      total++;
      if (io.sram_write !== 1'b1) begin bad++; $display("FAIL ria_write: got %b want 1", io.sram_write); end
      rst = 1;
      ref_mem[7] = wd;  // strobe was high on the reset edge
      @(negedge clk);
      rst = 0;
      ref_rd[0] = '0; ref_rd[1] = '0; ref_last = 1;
      total++;
      if ({io.bus_gnt, io.bus_done, io.bus_err, io.core_gnt, io.core_done, io.core_err,
           io.sram_read, io.sram_write, io.busy} !== 9'b0 || io.sram_addr !== '0 || io.sram_wdata !== '0) begin
         bad++; $display("FAIL ria_clear: flags %b addr %h", {io.bus_gnt, io.bus_done, io.bus_err,
            io.core_gnt, io.core_done, io.core_err, io.sram_read, io.sram_write, io.busy}, io.sram_addr);
      end
      @(negedge clk);
      total++;
      if (io.bus_done !== 1'b0 || io.busy !== 1'b0) begin
         bad++; $display("FAIL ria_nodone: done %b busy %b want 0 0", io.bus_done, io.busy);
      end
      drive(0, 1, 0, 16'd7, '0);
      drive(1, 1, 0, 16'd1, '0);
      @(negedge clk);
      total++;
      if ({io.bus_gnt, io.core_gnt} !== 2'b10) begin
         bad++; $display("FAIL ria_tie: got %b want 10", {io.bus_gnt, io.core_gnt});
      end
      drive(0, 0, 0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      ref_rd[0] = ref_mem[7];
      total++;
      if (io.bus_rdata !== ref_rd[0]) begin bad++; $display("FAIL ria_rd: got %h want %h", io.bus_rdata, ref_rd[0]); end
      @(negedge clk);
      @(negedge clk);
      drive(1, 0, 0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      ref_rd[1] = ref_mem[1];
      total++;
      if (io.core_rdata !== ref_rd[1]) begin bad++; $display("FAIL ria_crd: got %h want %h", io.core_rdata, ref_rd[1]); end
      @(negedge clk);
      ref_last = 1;
   endtask

   task automatic test_input_change();
      drive(1, 1, 0, 16'd0, '0);
      @(negedge clk);
      total++;
      if (io.core_gnt !== 1'b1) begin bad++; $display("FAIL ic_gnt: got %b want 1", io.core_gnt); end
      drive(1, 0, 1, 16'd5, rnd128());
      @(negedge clk);
      total++;
      if (io.sram_addr !== 16'd0 || {io.sram_read, io.sram_write} !== 2'b10) begin
         bad++; $display("FAIL ic_addr: got a%h rw%b want a0 rw10", io.sram_addr, {io.sram_read, io.sram_write});
      end
      @(negedge clk);
      ref_rd[1] = ref_mem[0];
      total++;
      if (io.core_rdata !== ref_rd[1]) begin bad++; $display("FAIL ic_rd: got %h want %h", io.core_rdata, ref_rd[1]); end
      @(negedge clk);
      clear_inputs();
      ref_last = 1;
   endtask

   task automatic test_random();
      logic          pend [2];
      logic          rw   [2];
      logic [AW-1:0] ra   [2];
      logic [DW-1:0] rd   [2];
      int            w;
      int            p;
      for (int it = 0; it < 150; it++) begin
         p = $urandom_range(1, 3);
         for (int k = 0; k < 2; k++) begin
            pend[k] = p[k];
            rw[k]   = $urandom_range(0, 1);
            ra[k]   = ($urandom_range(0, 4) == 0) ? AW'($urandom_range(DEPTH, 65535))
                                                  : AW'($urandom_range(0, DEPTH - 1));
            rd[k]   = rnd128();
            drive(k, pend[k], rw[k], ra[k], rd[k]);
         end
         for (int s = 0; s < 2; s++) begin
            if (pend[0] || pend[1]) begin
               w = (pend[0] && pend[1]) ? (ref_last == 0 ? 1 : 0) : (pend[0] ? 0 : 1);
               @(negedge clk);
               total++;
               if ({io.bus_gnt, io.core_gnt} !== ((w == 0) ? 2'b10 : 2'b01)) begin
                  bad++; $display("FAIL rnd_gnt it%0d: got %b want owner %0d", it, {io.bus_gnt, io.core_gnt}, w);
               end
               drive(w, 0, $urandom_range(0, 1), AW'($urandom), rnd128());
               pend[w] = 0;
               ref_last = w;
               if (ra[w] >= AW'(DEPTH)) begin
                  total++;
                  if ({io.bus_done, io.bus_err, io.core_done, io.core_err, io.sram_read, io.sram_write}
                      !== ((w == 0) ? 6'b110000 : 6'b001100)) begin
                     bad++; $display("FAIL rnd_err it%0d: got %b owner %0d", it, {io.bus_done, io.bus_err,
                        io.core_done, io.core_err, io.sram_read, io.sram_write}, w);
                  end
               end else begin
                  @(negedge clk);
                  total++;
                  if ({io.sram_read, io.sram_write} !== {~rw[w], rw[w]} || io.sram_addr !== ra[w] ||
                      io.sram_wdata !== (rw[w] ? rd[w] : '0)) begin
                     bad++; $display("FAIL rnd_acc it%0d: rw %b addr %h want rw %b addr %h", it,
                        {io.sram_read, io.sram_write}, io.sram_addr, {~rw[w], rw[w]}, ra[w]);
                  end
                  @(negedge clk);
                  if (rw[w]) ref_mem[ra[w]] = rd[w];
                  else ref_rd[w] = ref_mem[ra[w]];
                  total++;
                  if ({io.bus_done, io.bus_err, io.core_done, io.core_err} !== ((w == 0) ? 4'b1000 : 4'b0010)) begin
                     bad++; $display("FAIL rnd_done it%0d: got %b owner %0d", it,
                        {io.bus_done, io.bus_err, io.core_done, io.core_err}, w);
                  end
               end
               total++;
               if (io.bus_rdata !== ref_rd[0] || io.core_rdata !== ref_rd[1]) begin
                  bad++; $display("FAIL rnd_rdata it%0d: got %h/%h want %h/%h", it,
                     io.bus_rdata, io.core_rdata, ref_rd[0], ref_rd[1]);
               end
               @(negedge clk);
               total++;
               if (io.busy !== 1'b0) begin bad++; $display("FAIL rnd_idle it%0d: busy %b want 0", it, io.busy); end
            end
         end
      end
   endtask

   initial begin
      clear_inputs();
      fill = 0; fill_idx = '0; fill_data = '0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk);
         fill = 1; fill_idx = AIW'(i); fill_data = rnd128();
         ref_mem[i] = fill_data;
      end
      @(negedge clk);
      fill = 0;
      test_reset();
      test_bus_write();
      test_tie();
      test_back_to_back();
      test_out_of_range();
      test_reset_in_access();
      test_input_change();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
